seq_div: RTL and testbench

Sequential restoring divider that inverts the 4-bit combinational multiplier's operation: it takes an 8-bit dividend and a 4-bit divisor and returns an 8-bit quotient and a 4-bit remainder. It computes one quotient bit per clock over a fixed 8-cycle iteration window under a start/done handshake. It sits beside the multiplier in the same arithmetic datapath. The UVM environment uses it for round-trip checks (multiplier product in, multiplier operand back out).

---
 rtl/seq_div.sv | 106 ++++++++++
 tb/tb_seq_div.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// seq_div: sequential restoring divider, 8-bit dividend by 4-bit divisor.
// Produces one quotient bit per clock, MSB first, over a fixed 8-iteration
// window, with a start/done handshake. A zero divisor keeps the same
// latency and reports q=8'hFF, r=0 with dz raised.
module seq_div (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] y,
   input  logic [3:0] b,
   output logic [7:0] q,
   output logic [3:0] r,
   output logic       dz,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] dividend_sr;
   logic [3:0] divisor;
   logic [4:0] pr;
   logic [7:0] quot_sr;
   logic [2:0] iter_cnt;

   logic [4:0] pr_shift;
   logic [4:0] pr_next;
   logic       q_bit;
   logic [7:0] quot_next;

   // One restoring step: bring in the next dividend bit, trial-subtract the divisor.
   always_comb begin
      pr_shift  = {pr[3:0], dividend_sr[7]};
      q_bit     = (pr_shift >= {1'b0, divisor});
      pr_next   = q_bit ? (pr_shift - {1'b0, divisor}) : pr_shift;
      quot_next = {quot_sr[6:0], q_bit};
   end

   // Control FSM, iteration datapath and registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         dividend_sr <= 8'h00;
         divisor     <= 4'h0;
         pr          <= 5'h00;
         quot_sr     <= 8'h00;
         iter_cnt    <= 3'd0;
         q           <= 8'h00;
         r           <= 4'h0;
         dz          <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  dividend_sr <= y;
                  divisor     <= b;
                  pr          <= 5'h00;
                  quot_sr     <= 8'h00;
                  iter_cnt    <= 3'd7;
                  busy        <= 1'b1;
                  state       <= CALC;
               end
            end
            CALC: begin
               dividend_sr <= {dividend_sr[6:0], 1'b0};
               pr          <= pr_next;
               quot_sr     <= quot_next;
               if (iter_cnt == 3'd0) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
                  if (divisor == 4'h0) begin
                     q  <= 8'hFF;
                     r  <= 4'h0;
                     dz <= 1'b1;
                  end else begin
                     q  <= quot_next;
                     r  <= pr_next[3:0];
                     dz <= 1'b0;
                  end
               end else begin
                  iter_cnt <= iter_cnt - 3'd1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div.sv
// Testbench for seq_div: directed vectors with literal expectations plus a
// per-cycle comparison against an arithmetic/timeline reference model.
module tb_seq_div;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] y = 8'h00;
   logic [3:0] b = 4'h0;
   logic [7:0] q;
   logic [3:0] r;
   logic       dz;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;
   int cycles = 0;

   // Reference model state: phase counts edges since the accepted start.
   int phase = -1;
   int m_y = 0;
   int m_b = 0;
   int m_q = 0;
   int m_r = 0;
   int m_dz = 0;
   bit model_valid = 1'b0;

   seq_div dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .y     (y),
      .b     (b),
      .q     (q),
      .r     (r),
      .dz    (dz),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   // Free-running edge counter used to measure result spacing.
   always @(posedge clk) cycles++;

   task automatic checkOutput(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference model: quotient/remainder by plain arithmetic, timing by edge count.
   always @(posedge clk) begin
      if (rst) begin
         phase = -1;
         m_q = 0;
         m_r = 0;
         m_dz = 0;
         model_valid = 1'b1;
      end else if (phase < 0) begin
         if (start) begin
            phase = 0;
            m_y = int'(y);
            m_b = int'(b);
         end
      end else begin
         phase++;
         if (phase == 8) begin
            if (m_b == 0) begin
               m_q = 255;
               m_r = 0;
               m_dz = 1;
            end else begin
               m_q = m_y / m_b;
               m_r = m_y % m_b;
               m_dz = 0;
            end
         end else if (phase == 9) begin
            phase = -1;
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      if (model_valid) begin
         checkOutput("cyc_busy", int'(busy), (phase >= 0 && phase <= 7) ? 1 : 0);
         checkOutput("cyc_done", int'(done), (phase == 8) ? 1 : 0);
         checkOutput("cyc_q", int'(q), m_q);
         checkOutput("cyc_r", int'(r), m_r);
         checkOutput("cyc_dz", int'(dz), m_dz);
      end
   end

   // Present one operation: start high for exactly one sampling edge.
   task automatic applyStimulus(input logic [7:0] yy, input logic [3:0] bb);
      @(negedge clk);
      start = 1'b1;
      y = yy;
      b = bb;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for done; returns negedges elapsed after the accept cycle.
   task automatic waitDone(output int lat);
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic runOp(input logic [7:0] yy, input logic [3:0] bb,
                        input int eq, input int er, input int edz, input string nm);
      int lat;
      applyStimulus(yy, bb);
      waitDone(lat);
      checkOutput({nm, "_latency"}, lat, 8);
      checkOutput({nm, "_q"}, int'(q), eq);
      checkOutput({nm, "_r"}, int'(r), er);
      checkOutput({nm, "_dz"}, int'(dz), edz);
   endtask

   task automatic countDones(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done) cnt++;
      end
   endtask

   initial begin
      int lat;
      int cnt;
      int prev_done;

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("rst_q", int'(q), 0);
      checkOutput("rst_r", int'(r), 0);
      checkOutput("rst_dz", int'(dz), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      rst = 1'b0;

      // Main function.
      runOp(8'd143, 4'd11, 13, 0, 0, "d143_11");
      runOp(8'd100, 4'd7, 14, 2, 0, "d100_7");

      // Boundaries.
      runOp(8'd255, 4'd1, 255, 0, 0, "d255_1");
      runOp(8'd3, 4'd15, 0, 3, 0, "d3_15");
      runOp(8'd0, 4'd9, 0, 0, 0, "d0_9");
      runOp(8'd255, 4'd15, 17, 0, 0, "d255_15");

      // Divide by zero, then a normal op clears dz.
      runOp(8'd5, 4'd0, 255, 0, 1, "d5_0");
      runOp(8'd20, 4'd4, 5, 0, 0, "d20_4");

      // Stray starts during CALC and operand changes after acceptance.
      applyStimulus(8'd30, 4'd4);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 2 || k == 7) begin
            start = 1'b1;
            y = 8'd99;
            b = 4'd3;
         end else if (k == 3) begin
            start = 1'b0;
            y = 8'd201;
            b = 4'd6;
         end else if (k == 8) begin
            start = 1'b0;
         end
      end
      checkOutput("stray_done", int'(done), 1);
      checkOutput("stray_q", int'(q), 7);
      checkOutput("stray_r", int'(r), 2);
      countDones(15, cnt);
      checkOutput("stray_no_extra_done", cnt, 0);

      // Reset in the middle of an operation.
      applyStimulus(8'd200, 4'd9);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_q", int'(q), 0);
      checkOutput("abort_r", int'(r), 0);
      checkOutput("abort_dz", int'(dz), 0);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_done", int'(done), 0);
      countDones(12, cnt);
      checkOutput("abort_no_done", cnt, 0);
      runOp(8'd200, 4'd9, 22, 2, 0, "d200_9");

      // Round trip with start held high: results exactly 10 cycles apart.
      prev_done = -1;
      @(negedge clk);
      start = 1'b1;
      for (int a = 1; a <= 15; a++) begin
         for (int d = 1; d <= 15; d++) begin
            y = 8'(a * d);
            b = 4'(d);
            lat = 0;
            if (done) begin
               @(negedge clk);
            end
            while (!done && lat < 30) begin
               @(negedge clk);
               lat++;
            end
            checkOutput("rt_timeout", int'(done), 1);
            checkOutput("rt_q", int'(q), a);
            checkOutput("rt_r", int'(r), 0);
            if (prev_done >= 0) begin
               checkOutput("rt_spacing", cycles - prev_done, 10);
            end
            prev_done = cycles;
         end
      end
      start = 1'b0;
      repeat (12) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
